// File: rtl/obi_watchdog_multi.sv
// obi_watchdog_multi: multi-channel watchdog on an OBI subordinate port.
// Each channel has a timeout counter, an optional early-kick window, a
// set-only LOCK and a bark (irq) -> bite (system reset pulse) escalation.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   obi_req_i  OBI request (gnt is returned combinationally, no stall)
//   obi_rsp_o  OBI response (rvalid one cycle after grant)
//   irq_o      per-channel bark interrupt, registered level
//   sys_rst_o  bite reset request, RstPulseCycles-long active-high pulse
//
// Register map, channel c at c*0x10:
//   0x0 CTRL    [0]EN [1]WIN [2]IRQEN [3]LOCK [8]BARK(W1C) [9]BITTEN(RO)
//   0x4 TIMEOUT 0x8 WINDOW  0xC KICK (write: kick, read: live counter)

package obi_watchdog_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        sbr_obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;
endpackage

// One watchdog channel: registers, counter and bark/bite FSM.
module obi_watchdog_chan #(
    parameter int unsigned CounterWidth = 32,
    parameter logic [31:0] KickKey      = 32'h5A5A_A5A5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tick_i,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [1:0]  reg_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        irq_o,
    output logic        bite_o
);
    localparam int unsigned CW = CounterWidth;

    typedef enum logic [1:0] {IDLE, RUN, BARK, BITE} state_e;
    state_e state_q, state_d;

    logic          en_q, en_d, win_q, win_d, irqen_q, irqen_d, lock_q, lock_d;
    logic          bark_q, bark_d, bitten_q, bitten_d, irq_q;
    logic [CW-1:0] timeout_q, timeout_d, window_q, window_d, cnt_q, cnt_d, thr;
    logic          wr_ctrl, wr_tmo, wr_win, wr_kick, key_ok, active;
    logic          kick_ok, win_bad, expire, sw_dis, ctrl_change, go_bite;

    assign wr_ctrl     = sel_i & we_i & (reg_i == 2'd0);
    assign wr_tmo      = sel_i & we_i & (reg_i == 2'd1);
    assign wr_win      = sel_i & we_i & (reg_i == 2'd2);
    assign wr_kick     = sel_i & we_i & (reg_i == 2'd3);
    assign key_ok      = (wdata_i == KickKey);
    assign active      = (state_q == RUN) | (state_q == BARK);
    assign kick_ok     = wr_kick & key_ok & active & (~win_q | (cnt_q >= window_q));
    assign win_bad     = wr_kick & key_ok & active & win_q & (cnt_q < window_q);
    // TIMEOUT=0 behaves like TIMEOUT=1
    assign thr         = (timeout_q == '0) ? '0 : timeout_q - 1'b1;
    assign expire      = tick_i & active & (cnt_q >= thr);
    assign sw_dis      = wr_ctrl & ~lock_q & ~wdata_i[0];
    // A locked CTRL write is only an error if it tries to change a locked field
    assign ctrl_change = (wdata_i[2:0] != {irqen_q, win_q, en_q});

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        win_d     = win_q;
        irqen_d   = irqen_q;
        lock_d    = lock_q;
        bark_d    = bark_q;
        bitten_d  = bitten_q;
        timeout_d = timeout_q;
        window_d  = window_q;
        cnt_d     = cnt_q;
        err_o     = 1'b0;
        go_bite   = 1'b0;

        if (wr_ctrl) begin
            if (lock_q) err_o = ctrl_change;
            else        {irqen_d, win_d, en_d} = wdata_i[2:0];
            lock_d = lock_q | wdata_i[3];
            if (wdata_i[8]) bark_d = 1'b0;
        end
        if (wr_tmo) begin
            if (lock_q) err_o = 1'b1;
            else        timeout_d = wdata_i[CW-1:0];
        end
        if (wr_win) begin
            if (lock_q) err_o = 1'b1;
            else        window_d = wdata_i[CW-1:0];
        end
        if (wr_kick && !key_ok) err_o = 1'b1;

        // Software disable outranks any expiry on the same cycle
        if (sw_dis) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (en_d) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
                RUN, BARK: begin
                    if (win_bad) begin
                        go_bite = 1'b1;
                    end else if (kick_ok) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else if (expire) begin
                        if (state_q == RUN) begin
                            bark_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = BARK;
                        end else begin
                            go_bite = 1'b1;
                        end
                    end else if (tick_i) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BITE: begin
                    state_d = en_q ? RUN : IDLE;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end

        // Expiry bite and window violation merge into one bite
        if (go_bite) begin
            state_d  = BITE;
            bitten_d = 1'b1;
            cnt_d    = '0;
            if (!lock_d) en_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            win_q     <= 1'b0;
            irqen_q   <= 1'b0;
            lock_q    <= 1'b0;
            bark_q    <= 1'b0;
            bitten_q  <= 1'b0;
            timeout_q <= '1;
            window_q  <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            win_q     <= win_d;
            irqen_q   <= irqen_d;
            lock_q    <= lock_d;
            bark_q    <= bark_d;
            bitten_q  <= bitten_d;
            timeout_q <= timeout_d;
            window_q  <= window_d;
            cnt_q     <= cnt_d;
            irq_q     <= bark_q & irqen_q;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            2'd0: rdata_o = {22'b0, bitten_q, bark_q, 4'b0, lock_q, irqen_q, win_q, en_q};
            2'd1: rdata_o = 32'(timeout_q);
            2'd2: rdata_o = 32'(window_q);
            default: rdata_o = 32'(cnt_q);
        endcase
    end

    assign irq_o  = irq_q;
    assign bite_o = (state_q == BITE);
endmodule

module obi_watchdog_multi #(
    parameter obi_watchdog_pkg::obi_cfg_t ObiCfg = obi_watchdog_pkg::SbrObiCfg,
    parameter type obi_req_t           = obi_watchdog_pkg::sbr_obi_req_t,
    parameter type obi_rsp_t           = obi_watchdog_pkg::sbr_obi_rsp_t,
    parameter int unsigned NumChannels    = 4,
    parameter int unsigned CounterWidth   = 32,
    parameter int unsigned PrescaleDiv    = 1,
    parameter int unsigned RstPulseCycles = 16,
    parameter logic [31:0] KickKey        = 32'h5A5A_A5A5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  obi_req_t               obi_req_i,
    output obi_rsp_t               obi_rsp_o,
    output logic [NumChannels-1:0] irq_o,
    output logic                   sys_rst_o
);
    localparam int unsigned DW = ObiCfg.DataWidth;
    localparam int unsigned PW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam int unsigned RW = $clog2(RstPulseCycles + 1);

    logic [27:0]                      ch_idx;
    logic                             ch_ok, tick;
    logic [NumChannels-1:0]           ch_sel, ch_err, ch_bite;
    logic [NumChannels-1:0][DW-1:0]   ch_rdata;
    logic [DW-1:0]                    rd_mux, rdata_q;
    logic                             err_mux, err_q, rvalid_q;
    logic [0:0]                       rid_q;
    logic [PW-1:0]                    psc_q;
    logic [RW-1:0]                    rst_cnt_q;
    logic                             unused_ok;

    assign ch_idx    = obi_req_i.a.addr[31:4];
    assign ch_ok     = (ch_idx < 28'(NumChannels));
    assign tick      = (psc_q == PW'(PrescaleDiv - 1));
    assign unused_ok = ^{obi_req_i.a.be, obi_req_i.a.addr[1:0]};

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        assign ch_sel[c] = obi_req_i.req & ch_ok & (ch_idx == 28'(c));
        obi_watchdog_chan #(
            .CounterWidth (CounterWidth),
            .KickKey      (KickKey)
        ) u_chan (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .tick_i  (tick),
            .sel_i   (ch_sel[c]),
            .we_i    (obi_req_i.a.we),
            .reg_i   (obi_req_i.a.addr[3:2]),
            .wdata_i (obi_req_i.a.wdata),
            .rdata_o (ch_rdata[c]),
            .err_o   (ch_err[c]),
            .irq_o   (irq_o[c]),
            .bite_o  (ch_bite[c])
        );
    end

    // Out-of-range channel: err=1, rdata=0
    always_comb begin
        rd_mux  = '0;
        err_mux = ~ch_ok;
        for (int c = 0; c < NumChannels; c++) begin
            if (ch_sel[c]) begin
                rd_mux  = ch_rdata[c];
                err_mux = ch_err[c];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psc_q     <= '0;
            rst_cnt_q <= '0;
        end else begin
            rvalid_q <= obi_req_i.req;
            if (obi_req_i.req) begin
                rid_q   <= obi_req_i.a.aid;
                rdata_q <= rd_mux;
                err_q   <= err_mux;
            end
            psc_q <= tick ? '0 : psc_q + 1'b1;
            // Any bite (re)loads the pulse, so overlapping bites extend it
            if (|ch_bite)              rst_cnt_q <= RW'(RstPulseCycles);
            else if (rst_cnt_q != '0)  rst_cnt_q <= rst_cnt_q - 1'b1;
        end
    end

    always_comb begin
        obi_rsp_o          = '0;
        obi_rsp_o.gnt      = obi_req_i.req;
        obi_rsp_o.rvalid   = rvalid_q;
        obi_rsp_o.r.rdata  = rdata_q;
        obi_rsp_o.r.rid    = rid_q;
        obi_rsp_o.r.err    = err_q;
    end

    assign sys_rst_o = (rst_cnt_q != '0);
endmodule

// File: tb/tb_obi_watchdog_multi.sv
module tb_obi_watchdog_multi;
    import obi_watchdog_pkg::*;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    sbr_obi_req_t req;
    sbr_obi_rsp_t rsp;
    logic [3:0]   irq;
    logic         sys_rst;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] rd;
    logic        rerr;

    obi_watchdog_multi dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .irq_o     (irq),
        .sys_rst_o (sys_rst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction; the grant edge is the cycle count on return.
    task automatic xfer(input logic [31:0] addr, input logic we, input logic [31:0] wd);
        logic [0:0] aid;
        aid       = 1'($urandom);
        req.req   = 1'b1;
        req.a.addr = addr;
        req.a.we  = we;
        req.a.be  = 4'hF;
        req.a.wdata = wd;
        req.a.aid = aid;
        #1;
        chk("gnt", 32'(rsp.gnt), 32'd1);
        @(posedge clk);
        #1;
        rd   = rsp.r.rdata;
        rerr = rsp.r.err;
        chk("rvalid", 32'(rsp.rvalid), 32'd1);
        chk("rid", 32'(rsp.r.rid), 32'(aid));
        req.req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        xfer(addr, 1'b1, wd);
    endtask

    task automatic rdreg(input logic [31:0] addr);
        xfer(addr, 1'b0, 32'h0);
    endtask

    // Sample 1ns after edge number t.
    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e, e1, lc, t, d, L;
        req = '0;
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_sys_rst", 32'(sys_rst), 32'd0);
        chk("rst_rvalid", 32'(rsp.rvalid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        rdreg(32'h04); chk("rst_timeout", rd, 32'hFFFF_FFFF);
        rdreg(32'h08); chk("rst_window", rd, 32'h0);
        rdreg(32'h00); chk("rst_ctrl", rd, 32'h0);

        // out-of-range channel
        rdreg(32'h40); chk("bad_ch_rd_err", 32'(rerr), 32'd1); chk("bad_ch_rdata", rd, 32'h0);
        wr(32'h44, 32'h5); chk("bad_ch_wr_err", 32'(rerr), 32'd1);

        // bark then bite on ch0
        wr(32'h04, 32'd10);
        wr(32'h00, 32'h5); e = cyc;
        wait_until(e + 10); chk("bark_early", 32'(irq), 32'h0);
        wait_until(e + 11); chk("bark_irq", 32'(irq), 32'h1);
        rdreg(32'h00); chk("bark_ctrl", rd, 32'h105);
        wait_until(e + 20); chk("bite_early", 32'(sys_rst), 32'd0);
        wait_until(e + 21); chk("bite_start", 32'(sys_rst), 32'd1);
        wait_until(e + 36); chk("bite_last", 32'(sys_rst), 32'd1);
        wait_until(e + 37); chk("bite_end", 32'(sys_rst), 32'd0);
        rdreg(32'h00); chk("bite_ctrl", rd, 32'h304);
        chk("bite_irq_held", 32'(irq), 32'h1);
        wr(32'h00, 32'h100); chk("w1c_err", 32'(rerr), 32'd0);
        wait_until(cyc + 1); chk("w1c_irq", 32'(irq), 32'h0);

        // wrong key leaves counter alone
        wr(32'h00, 32'h1); e = cyc;
        wait_until(e + 3);
        wr(32'h0C, 32'h1234); chk("badkey_err", 32'(rerr), 32'd1);
        rdreg(32'h0C); chk("badkey_cnt", rd, 32'd4);
        wr(32'h0C, KEY); chk("kick_err", 32'(rerr), 32'd0);
        rdreg(32'h0C); chk("kick_cnt", rd, 32'd0);
        wr(32'h00, 32'h0);

        // window on ch1
        wr(32'h14, 32'd100);
        wr(32'h18, 32'd5);
        wr(32'h10, 32'h3); e = cyc;
        wait_until(e + 6);
        wr(32'h1C, KEY); chk("win_ok_err", 32'(rerr), 32'd0);
        rdreg(32'h1C); chk("win_ok_cnt", rd, 32'd0);
        chk("win_ok_norst", 32'(sys_rst), 32'd0);
        wait_until(e + 10);
        wr(32'h1C, KEY); chk("win_bad_pre", 32'(sys_rst), 32'd0);
        wait_until(e + 12); chk("win_bad_rst", 32'(sys_rst), 32'd1);
        wait_until(e + 27); chk("win_bad_last", 32'(sys_rst), 32'd1);
        wait_until(e + 28); chk("win_bad_end", 32'(sys_rst), 32'd0);
        rdreg(32'h10); chk("win_ctrl", rd, 32'h202);

        // ch1 and ch3 expire on the same tick, then bite together
        wr(32'h14, 32'd10);
        wr(32'h34, 32'd9);
        wr(32'h10, 32'h5); e1 = cyc;
        wr(32'h30, 32'h5);
        wait_until(e1 + 10); chk("multi_irq_pre", 32'(irq), 32'h0);
        wait_until(e1 + 11); chk("multi_irq", 32'(irq), 32'hA);
        wr(32'h34, 32'd10);
        wait_until(e1 + 20); chk("multi_rst_pre", 32'(sys_rst), 32'd0);
        wait_until(e1 + 21); chk("multi_rst", 32'(sys_rst), 32'd1);
        wait_until(e1 + 36); chk("multi_rst_last", 32'(sys_rst), 32'd1);
        wait_until(e1 + 37); chk("multi_rst_end", 32'(sys_rst), 32'd0);
        rdreg(32'h30); chk("multi_ctrl3", rd, 32'h304);
        wr(32'h10, 32'h100);
        wr(32'h30, 32'h100);

        // randomized kicks on ch2: counter = edges since last clear
        t = $urandom_range(8, 20);
        wr(32'h24, 32'(t));
        wr(32'h20, 32'h5); lc = cyc;
        repeat (10) begin
            d = $urandom_range(0, t - 3);
            wait_until(lc + d);
            rdreg(32'h2C); chk("rand_cnt", rd, 32'(d));
            wr(32'h2C, KEY ^ (32'h1 << $urandom_range(0, 31)));
            chk("rand_badkey_err", 32'(rerr), 32'd1);
            wr(32'h2C, KEY); lc = cyc;
            chk("rand_kick_err", 32'(rerr), 32'd0);
            chk("rand_irq", 32'(irq), 32'h0);
            chk("rand_rst", 32'(sys_rst), 32'd0);
        end
        wait_until(lc + t); chk("rand_exp_pre", 32'(irq), 32'h0);
        wait_until(lc + t + 1); chk("rand_exp_irq", 32'(irq), 32'h4);
        wr(32'h20, 32'h100);

        // lock on ch3
        wr(32'h34, 32'd6);
        wr(32'h30, 32'h9); L = cyc;
        wr(32'h34, 32'd2); chk("lock_tmo_err", 32'(rerr), 32'd1);
        rdreg(32'h34); chk("lock_tmo_kept", rd, 32'd6);
        wr(32'h30, 32'h8); chk("lock_en_err", 32'(rerr), 32'd1);
        wait_until(L + 12); chk("lock_bite_pre", 32'(sys_rst), 32'd0);
        wait_until(L + 13); chk("lock_bite", 32'(sys_rst), 32'd1);
        rdreg(32'h30); chk("lock_ctrl", rd, 32'h309);
        rdreg(32'h3C); chk("lock_restart", 32'(rd <= 32'd2), 32'd1);

        // reset in the middle of the pulse
        chk("midrst_pre", 32'(sys_rst), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_sys_rst", 32'(sys_rst), 32'd0);
        chk("midrst_irq", 32'(irq), 32'h0);
        #3;
        rst_n = 1'b1;
        rdreg(32'h30); chk("midrst_ctrl", rd, 32'h0);
        rdreg(32'h34); chk("midrst_tmo", rd, 32'hFFFF_FFFF);
        wait_until(cyc + 20); chk("midrst_quiet", 32'(sys_rst), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
